bus_arbiter: RTL and testbench

//  Shared-bus arbiter between N bus masters (mips32 cores, DMA) and the single memory port.

---
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: picks one of NUM_MASTERS requesters per cycle and muxes its strobes, address and data onto the single memory port.
// Latency: the grant and the memory-port mux are combinational, so a request is granted in the same cycle; owner and owner_vld are one cycle later.
// Backpressure: losing masters see m_bgrt_ high and hold breq_ low; a master that has held the bus MAX_HOLD cycles yields to any waiting master.
//
// Ports:
//   clk, reset_                      clock, synchronous active-low reset
//   m_breq_/m_read/m_write           per-master request (active-low) and strobes
//   m_adr/m_wdata                    per-master address/data, master i in slice i
//   m_bgrt_                          per-master grant, active-low, at most one low
//   mem_read/mem_write/mem_adr/mem_wdata   memory port, driven by the granted master
//   owner/owner_vld                  index of the master granted last cycle, and whether there was one
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MAX_HOLD    = 8
) (
    input  logic                              clk,
    input  logic                              reset_,
    input  logic [NUM_MASTERS-1:0]            m_breq_,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_adr,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
    output logic [NUM_MASTERS-1:0]            m_bgrt_,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_W-1:0]                 mem_adr,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic [$clog2(NUM_MASTERS)-1:0]    owner,
    output logic                              owner_vld
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    logic [IDX_W-1:0]       rr_ptr;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [NUM_MASTERS-1:0] req;
    logic                   others_req;
    logic                   cont;
    logic                   gnt_vld;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       scan_idx;

    // Grant selection. The current owner keeps the bus until its hold budget
    // runs out and someone else is waiting. rr_ptr always sits at owner+1
    // after a grant, so the round-robin scan naturally starts past the owner
    // when it is preempted.
    always_comb begin
        req        = ~m_breq_;
        others_req = |(req & ~(NUM_MASTERS'(1) << owner));
        cont       = owner_vld && req[owner] && ((hold_cnt < HOLD_MAX) || !others_req);
        gnt_vld    = 1'b0;
        gnt_idx    = '0;
        scan_idx   = '0;
        if (reset_) begin
            if (cont) begin
                gnt_vld = 1'b1;
                gnt_idx = owner;
            end else begin
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    scan_idx = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
                    if (!gnt_vld && req[scan_idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = scan_idx;
                    end
                end
            end
        end
    end

    // Memory-port mux; everything idles at zero with no grant (including reset).
    always_comb begin
        m_bgrt_   = '1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (gnt_vld) begin
            m_bgrt_[gnt_idx] = 1'b0;
            mem_read         = m_read[gnt_idx];
            mem_write        = m_write[gnt_idx];
            mem_adr          = m_adr[gnt_idx*ADDR_W +: ADDR_W];
            mem_wdata        = m_wdata[gnt_idx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            rr_ptr    <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            hold_cnt  <= '0;
        end else if (gnt_vld) begin
            rr_ptr    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            owner     <= gnt_idx;
            owner_vld <= 1'b1;
            if (owner_vld && (gnt_idx == owner)) begin
                hold_cnt <= (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end else begin
            owner_vld <= 1'b0;
            hold_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=1) share
// the same stimulus; expected grants come from the scenario tables below and the
// expected memory-port values from a small mux model of the driven inputs.
module tb_bus_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [9:0]  adr;
        logic [31:0] wd;
    } mem_t;

    typedef struct {
        string      tag;
        logic [3:0] g8;
        logic [3:0] g1;
        mem_t       m8;
        mem_t       m1;
    } sb_t;

    logic         clk = 1'b0;
    logic         reset_;
    logic [3:0]   m_breq_;
    logic [3:0]   m_read;
    logic [3:0]   m_write;
    logic [39:0]  m_adr;
    logic [127:0] m_wdata;

    logic [3:0]   bgrt8, bgrt1;
    logic         rd8, wr8, rd1, wr1;
    logic [9:0]   adr8, adr1;
    logic [31:0]  wd8, wd1;
    logic [1:0]   own8, own1;
    logic         vld8, vld1;

    int checks = 0;
    int failures = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(10), .DATA_W(32), .MAX_HOLD(8)) dut (
        .clk(clk), .reset_(reset_), .m_breq_(m_breq_), .m_read(m_read), .m_write(m_write),
        .m_adr(m_adr), .m_wdata(m_wdata), .m_bgrt_(bgrt8), .mem_read(rd8), .mem_write(wr8),
        .mem_adr(adr8), .mem_wdata(wd8), .owner(own8), .owner_vld(vld8)
    );

    bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(10), .DATA_W(32), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset_(reset_), .m_breq_(m_breq_), .m_read(m_read), .m_write(m_write),
        .m_adr(m_adr), .m_wdata(m_wdata), .m_bgrt_(bgrt1), .mem_read(rd1), .mem_write(wr1),
        .mem_adr(adr1), .mem_wdata(wd1), .owner(own1), .owner_vld(vld1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory port expected for a given active-low grant vector.
    function automatic mem_t mem_model(input logic [3:0] g);
        mem_t m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i] == 1'b0) begin
                m = {m_read[i], m_write[i], m_adr[i*10 +: 10], m_wdata[i*32 +: 32]};
            end
        end
        return m;
    endfunction

    // Drive one cycle at the falling edge, queue its expectations, then compare
    // the combinational outputs before the next rising edge.
    task automatic step(input string tag, input logic rst_v, input logic [3:0] breq,
                        input logic [3:0] e8, input logic [3:0] e1);
        sb_t e;
        @(negedge clk);
        reset_  = rst_v;
        m_breq_ = breq;
        e.tag = tag;
        e.g8  = e8;
        e.g1  = e1;
        e.m8  = mem_model(e8);
        e.m1  = mem_model(e1);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_bgrt8"}, 64'(bgrt8), 64'(e.g8));
        chk({e.tag, "_mem8"}, 64'({rd8, wr8, adr8, wd8}), 64'(e.m8));
        chk({e.tag, "_bgrt1"}, 64'(bgrt1), 64'(e.g1));
        chk({e.tag, "_mem1"}, 64'({rd1, wr1, adr1, wd1}), 64'(e.m1));
    endtask

    task automatic rst_cycle(input string tag);
        step(tag, 1'b0, 4'b1111, 4'b1111, 4'b1111);
    endtask

    initial begin
        logic [3:0] e8;
        logic [3:0] e1;

        reset_  = 1'b0;
        m_breq_ = 4'b1111;
        m_read  = 4'b1111;
        m_write = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m_adr[i*10 +: 10]   = 10'h100 + 10'(i);
            m_wdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        end

        // Reset forces the bus idle even with every master requesting.
        step("t1_rst_a", 1'b0, 4'b0000, 4'b1111, 4'b1111);
        step("t1_rst_b", 1'b0, 4'b0000, 4'b1111, 4'b1111);
        chk("t1_owner8", 64'(own8), 64'd0);
        chk("t1_vld8", 64'(vld8), 64'd0);
        chk("t1_owner1", 64'(own1), 64'd0);
        chk("t1_vld1", 64'(vld1), 64'd0);
        step("t1_first", 1'b1, 4'b0000, 4'b1110, 4'b1110);
        // MAX_HOLD=8 continues on m0; MAX_HOLD=1 rotates to m1.
        step("t1_second", 1'b1, 4'b0000, 4'b1110, 4'b1101);
        // Reset mid-access drops the grant in the same cycle, then scans from 0.
        step("t1_rst_mid", 1'b0, 4'b0000, 4'b1111, 4'b1111);
        step("t1_after", 1'b1, 4'b0000, 4'b1110, 4'b1110);
        rst_cycle("t1_rst_end");

        // Single master m1 reading the top address.
        m_read = 4'b0010;
        m_adr[10 +: 10] = 10'h3FF;
        step("t2_grant", 1'b1, 4'b1101, 4'b1101, 4'b1101);
        chk("t2_mem_read", 64'(rd8), 64'd1);
        chk("t2_mem_adr", 64'(adr8), 64'h3FF);
        step("t2_idle", 1'b1, 4'b1111, 4'b1111, 4'b1111);
        chk("t2_owner", 64'(own8), 64'd1);
        chk("t2_vld", 64'(vld8), 64'd1);
        step("t2_idle2", 1'b1, 4'b1111, 4'b1111, 4'b1111);
        chk("t2_vld_drop", 64'(vld8), 64'd0);
        chk("t2_owner_keep", 64'(own8), 64'd1);
        rst_cycle("t2_rst_end");

        // All four requesting: MAX_HOLD=1 rotates 0,1,2,3,0; MAX_HOLD=8 holds m0.
        m_read = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            e1 = ~(4'b0001 << (c % 4));
            step($sformatf("t3_c%0d", c), 1'b1, 4'b0000, 4'b1110, e1);
        end
        chk("t3_owner1_wrap", 64'(own1), 64'd3);
        rst_cycle("t3_rst_end");

        // m0 holds, m2 joins from cycle 2: m0 gets 8 in a row, m2 the 9th.
        step("t4_c1", 1'b1, 4'b1110, 4'b1110, 4'b1110);
        for (int c = 2; c <= 9; c++) begin
            e8 = (c <= 8) ? 4'b1110 : 4'b1011;
            e1 = (c % 2 == 0) ? 4'b1011 : 4'b1110;
            step($sformatf("t4_c%0d", c), 1'b1, 4'b1010, e8, e1);
        end
        rst_cycle("t4_rst_end");

        // m0 alone for 20 cycles never loses the bus; hold counter saturates.
        for (int c = 1; c <= 20; c++) begin
            step($sformatf("t5_c%0d", c), 1'b1, 4'b1110, 4'b1110, 4'b1110);
        end
        chk("t5_hold8_sat", 64'(dut.hold_cnt), 64'd7);
        chk("t5_hold1_sat", 64'(dut1.hold_cnt), 64'd0);
        // A competitor arriving at saturation wins immediately.
        step("t5_preempt", 1'b1, 4'b1100, 4'b1101, 4'b1101);
        rst_cycle("t5_rst_end");

        // m3 writes; m0 wiggles strobes without requesting and is ignored.
        m_read  = 4'b0001;
        m_write = 4'b1001;
        m_wdata[96 +: 32] = 32'hDEAD_BEEF;
        step("t6_write", 1'b1, 4'b0111, 4'b0111, 4'b0111);
        chk("t6_mem_write", 64'(wr8), 64'd1);
        chk("t6_mem_wdata", 64'(wd8), 64'hDEAD_BEEF);
        chk("t6_mem_read", 64'(rd8), 64'd0);
        step("t6_stray", 1'b1, 4'b1111, 4'b1111, 4'b1111);
        chk("t6_stray_read", 64'(rd8), 64'd0);
        chk("t6_stray_write", 64'(wr8), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
